// File: rtl/saturn_serial_arbiter_pkg.sv
// saturn_serial_arbiter_pkg: shared widths, FSM state encodings and defaults
// for the serial TX arbiter and its requester interface.
package saturn_serial_arbiter_pkg;
    localparam int CHAR_W = 8;
    localparam int CNT_W  = 10;
    localparam logic [CHAR_W-1:0] EOL_DEFAULT = 8'h0A;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;
endpackage

// File: rtl/saturn_serial_arbiter_if.sv
// saturn_serial_arbiter_if: requester-side and serial-side signals of the arbiter.
// slave is the arbiter view, master the requesters/serial-port view.
interface saturn_serial_arbiter_if #(parameter int NUM_REQ = 2);
    import saturn_serial_arbiter_pkg::*;
    logic [NUM_REQ*CHAR_W-1:0] i_req_char;
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        o_req_ack;
    logic [CHAR_W-1:0]         o_char_to_send;
    logic                      o_char_valid;
    logic                      i_serial_busy;
    logic [CNT_W-1:0]          o_char_counter;
    logic [1:0]                o_owner;
    logic                      o_locked;
    logic                      o_busy;
    logic                      o_error;
    modport slave (
        input  i_req_char, i_req_valid, i_serial_busy,
        output o_req_ack, o_char_to_send, o_char_valid, o_char_counter,
               o_owner, o_locked, o_busy, o_error
    );
    modport master (
        output i_req_char, i_req_valid, i_serial_busy,
        input  o_req_ack, o_char_to_send, o_char_valid, o_char_counter,
               o_owner, o_locked, o_busy, o_error
    );
endinterface

// File: rtl/saturn_serial_arbiter_rr_pick.sv
// saturn_rr_pick: combinational round-robin picker; returns the first set
// request at or after start_i, wrapping modulo N.
module saturn_rr_pick #(parameter int N = 2) (
    input  logic [N-1:0] req_i,
    input  logic [1:0]   start_i,
    output logic         found_o,
    output logic [1:0]   idx_o
);
    always_comb begin
        found_o = 1'b0;
        idx_o   = 2'd0;
        for (int i = N - 1; i >= 0; i--)
            for (int j = 0; j < N; j++)
                if (j == (int'(start_i) + i) % N && req_i[j]) begin
                    found_o = 1'b1;
                    idx_o   = 2'(j);
                end
    end
endmodule

// File: rtl/saturn_serial_arbiter.sv
// saturn_serial_arbiter: shares the saturn_serial TX port between NUM_REQ
// char sources, round-robin, paced on serial busy, with optional line lock.
module saturn_serial_arbiter
    import saturn_serial_arbiter_pkg::*;
#(
    parameter int              NUM_REQ       = 2,
    parameter bit              LINE_LOCK     = 1'b1,
    parameter logic [CHAR_W-1:0] EOL_CHAR    = EOL_DEFAULT,
    parameter int              BUSY_TIMEOUT  = 4,
    parameter int              LOCK_IDLE_MAX = 255
) (
    input logic i_clk,
    input logic i_reset_n,
    saturn_serial_arbiter_if.slave bus
);
    localparam int IW = $clog2(LOCK_IDLE_MAX + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    logic [1:0]         state_q, state_d, owner_q, owner_d, last_q, last_d;
    logic [CHAR_W-1:0]  char_q, char_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               valid_q, valid_d, locked_q, locked_d, err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic [TW-1:0]      to_q, to_d;
    logic [NUM_REQ-1:0] own_oh, elig;
    logic [1:0]         start, pick;
    logic               found, own_vld;
    logic [CHAR_W-1:0]  pick_chr;
    assign own_oh  = NUM_REQ'(1) << owner_q;
    assign own_vld = |(bus.i_req_valid & own_oh);
    assign elig    = locked_q ? bus.i_req_valid & own_oh : bus.i_req_valid;
    assign start   = (last_q == 2'(NUM_REQ - 1)) ? 2'd0 : last_q + 2'd1;
    saturn_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i(elig), .start_i(start), .found_o(found), .idx_o(pick)
    );
    always_comb begin
        pick_chr = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (pick == 2'(k)) pick_chr = bus.i_req_char[CHAR_W*k +: CHAR_W];
    end
    // Grant-time updates land together so valid, ack, counter and lock are seen in the ISSUE cycle.
    always_comb begin
        state_d  = state_q;
        char_d   = char_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        ack_d    = '0;
        idle_d   = '0;
        to_d     = '0;
        case (state_q)
            S_IDLE:
                if (!bus.i_serial_busy && found) begin
                    state_d = S_ISSUE;
                    char_d  = pick_chr;
                    owner_d = pick;
                    last_d  = pick;
                    valid_d = 1'b1;
                    ack_d   = NUM_REQ'(1) << pick;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (LINE_LOCK) locked_d = pick_chr != EOL_CHAR;
                end else if (locked_q && !own_vld) begin
                    if (idle_q == IW'(LOCK_IDLE_MAX - 1)) locked_d = 1'b0;
                    else idle_d = idle_q + IW'(1);
                end
            S_ISSUE: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY:
                if (bus.i_serial_busy) state_d = S_WAIT_DONE;
                else if (to_q == TW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else to_d = to_q + TW'(1);
            default: state_d = bus.i_serial_busy ? S_WAIT_DONE : S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            char_q   <= '0;
            owner_q  <= '0;
            last_q   <= 2'(NUM_REQ - 1);
            ack_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            idle_q   <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            idle_q   <= idle_d;
            to_q     <= to_d;
        end
    end
    assign bus.o_req_ack      = ack_q;
    assign bus.o_char_to_send = char_q;
    assign bus.o_char_valid   = valid_q;
    assign bus.o_char_counter = cnt_q;
    assign bus.o_owner        = owner_q;
    assign bus.o_locked       = locked_q;
    assign bus.o_busy         = state_q != S_IDLE;
    assign bus.o_error        = err_q;
endmodule

// File: tb/tb_saturn_serial_arbiter.sv
// tb_saturn_serial_arbiter: directed bench for the serial arbiter; u0 runs
// without line lock, u1 with lock and default parameters.
module tb_saturn_serial_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    saturn_serial_arbiter_if #(.NUM_REQ(2)) v0 ();
    saturn_serial_arbiter_if #(.NUM_REQ(2)) v1 ();
    saturn_serial_arbiter #(.LINE_LOCK(1'b0)) u0 (.i_clk(clk), .i_reset_n(rst_n), .bus(v0));
    saturn_serial_arbiter u1 (.i_clk(clk), .i_reset_n(rst_n), .bus(v1));

    int vec = 0;
    int miss = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // serial port model: busy rises the cycle after a valid pulse and stays high 5 cycles
    int left0 = 0, left1 = 0;
    logic bm0 = 1'b0, bm1 = 1'b0, bf1 = 1'b0, en1 = 1'b1;
    assign v0.i_serial_busy = bm0;
    assign v1.i_serial_busy = bm1 | bf1;
    always @(negedge clk) begin
        bm0 = left0 > 0;
        if (left0 > 0) left0--;
        if (v0.o_char_valid) left0 = 5;
        bm1 = left1 > 0;
        if (left1 > 0) left1--;
        if (v1.o_char_valid && en1) left1 = 5;
    end

    // u1 requesters: char queues popped on ack
    logic [7:0] q0[$], q1[$];
    always @(negedge clk) begin
        if (v1.o_req_ack[0] && q0.size() > 0) void'(q0.pop_front());
        if (v1.o_req_ack[1] && q1.size() > 0) void'(q1.pop_front());
        v1.i_req_valid = {q1.size() > 0, q0.size() > 0};
        v1.i_req_char  = {q1.size() > 0 ? q1[0] : 8'h00, q0.size() > 0 ? q0[0] : 8'h00};
    end

    int n0 = 0, n1 = 0, a00 = 0, a01 = 0, alt_bad = 0;
    logic [7:0] prev0 = 8'h00;
    logic [7:0] c1[$];
    logic       lk1[$];
    logic [1:0] ow1[$];
    always @(negedge clk) begin
        if (v0.o_char_valid) begin
            if (n0 > 0 && v0.o_char_to_send == prev0) alt_bad++;
            if (v0.o_req_ack != (v0.o_char_to_send == 8'h41 ? 2'b01 : 2'b10)) alt_bad++;
            prev0 = v0.o_char_to_send;
            n0++;
        end
        if (v0.o_req_ack[0]) a00++;
        if (v0.o_req_ack[1]) a01++;
        if (v1.o_char_valid) begin
            c1.push_back(v1.o_char_to_send);
            lk1.push_back(v1.o_locked);
            ow1.push_back(v1.o_owner);
            n1++;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask
    task automatic wait_n1(int target, int bound, string tag);
        int t = 0;
        while (n1 < target && t < bound) begin
            tick();
            t++;
        end
        check(tag, 32'(n1 >= target), 1);
    endtask
    task automatic wait_idle1(int bound, string tag);
        int t = 0;
        while (v1.o_busy && t < bound) begin
            tick();
            t++;
        end
        check(tag, 32'(v1.o_busy), 0);
    endtask

    initial begin
        int t;
        v0.i_req_valid = 2'b00;
        v0.i_req_char  = 16'h0000;
        tick(3);
        check("rst_u0", {v0.o_char_valid, v0.o_req_ack, v0.o_char_counter, v0.o_owner,
                         v0.o_locked, v0.o_busy, v0.o_error}, 0);
        check("rst_u1", {v1.o_char_valid, v1.o_req_ack, v1.o_char_counter, v1.o_owner,
                         v1.o_locked, v1.o_busy, v1.o_error}, 0);
        rst_n = 1'b1;
        tick(2);
        // alternation without lock, then counter wrap, then drop before ack
        v0.i_req_char  = {8'h42, 8'h41};
        v0.i_req_valid = 2'b11;
        t = 0;
        while (n0 < 1 && t < 20) begin tick(); t++; end
        check("alt_first", prev0, 8'h41);
        t = 0;
        while (n0 < 1023 && t < 20000) begin tick(); t++; end
        check("cnt_1023", v0.o_char_counter, 1023);
        t = 0;
        while (n0 < 1024 && t < 50) begin tick(); t++; end
        check("cnt_wrap", v0.o_char_counter, 0);
        v0.i_req_valid = 2'b00;
        tick(20);
        check("drop_no_ack", n0, 1024);
        check("ack0_cnt", a00, 512);
        check("ack1_cnt", a01, 512);
        check("alt_bad", alt_bad, 0);
        check("u0_unlocked", v0.o_locked, 0);
        // single char after reset
        q0.push_back(8'h41);
        wait_n1(1, 20, "t1_seen");
        check("t1_char", v1.o_char_to_send, 8'h41);
        check("t1_ack", v1.o_req_ack, 2'b01);
        check("t1_cnt", v1.o_char_counter, 1);
        check("t1_owner", v1.o_owner, 0);
        wait_idle1(20, "t1_idle");
        check("t1_lock", v1.o_locked, 1);
        // locked line "HI\n" ahead of req1 'X'
        q0.push_back(8'h48); q0.push_back(8'h49); q0.push_back(8'h0A);
        q1.push_back(8'h58);
        wait_n1(5, 100, "t3_seen");
        check("t3_seq", {c1[1], c1[2], c1[3], c1[4]}, 32'h48490A58);
        check("t3_lock", {lk1[1], lk1[2], lk1[3], lk1[4]}, 4'b1101);
        check("t3_owner", ow1[4], 1);
        wait_idle1(20, "t3_idle");
        // lock held by idle req1 blocks req0 until the idle limit
        q0.push_back(8'h59);
        tick(200);
        check("t4_blocked", n1, 5);
        check("t4_locked", v1.o_locked, 1);
        wait_n1(6, 100, "t4_release");
        check("t4_char", c1[5], 8'h59);
        check("t4_owner", ow1[5], 0);
        wait_idle1(20, "t4_idle");
        // busy never rises
        en1 = 1'b0;
        q0.push_back(8'h5A);
        wait_n1(7, 20, "t5_seen");
        tick(4);
        check("t5_err_early", v1.o_error, 0);
        tick(1);
        check("t5_err", v1.o_error, 1);
        check("t5_idle", v1.o_busy, 0);
        en1 = 1'b1;
        q0.push_back(8'h57);
        wait_n1(8, 20, "t5_next");
        check("t5_char", v1.o_char_to_send, 8'h57);
        wait_idle1(20, "t5_done");
        check("t5_sticky", v1.o_error, 1);
        // reset during WAIT_DONE with the serial port still busy
        q0.push_back(8'h56);
        wait_n1(9, 20, "t6_seen");
        tick(3);
        check("t6_busy", v1.o_busy, 1);
        bf1 = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_rst", {v1.o_char_valid, v1.o_req_ack, v1.o_char_counter, v1.o_owner,
                         v1.o_locked, v1.o_busy, v1.o_error}, 0);
        tick(2);
        rst_n = 1'b1;
        q0.push_back(8'h55);
        tick(10);
        check("t6_hold", n1, 9);
        bf1 = 1'b0;
        wait_n1(10, 20, "t6_after");
        check("t6_char", v1.o_char_to_send, 8'h55);
        check("t6_cnt", v1.o_char_counter, 1);
        check("t6_err", v1.o_error, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
